// File: rtl/musk_reg_writeback.sv
// Architectural register file plus issue scoreboard.
// Issue sets a scoreboard bit on reserve. Writeback stores the result and clears the bit.
// Flush drops every reservation.
// Register ids: 0..REG_FILE_SIZE-1 are GPRs (rax=0, rcx=1, rdx=2, rbx=3, rsp=4, ...).
// Ids at or above REG_FILE_SIZE (rip, rimm, rnil, rv0, rv8, rsyscall) never touch state.
// Packed value layout: {val[63:0], cf, zf, sf, of}.
module musk_reg_writeback #(
    parameter int unsigned REG_FILE_SIZE = 16,
    parameter int unsigned REG_ID_W      = 5,
    parameter int unsigned REG_VAL_W     = 68,
    parameter logic [63:0] RSP_INIT      = 64'h0
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 rsv_valid,
    input  logic [REG_ID_W-1:0]                  rsv_id,
    input  logic                                 wb_valid,
    input  logic [REG_ID_W-1:0]                  wb_id,
    input  logic [REG_VAL_W-1:0]                 wb_val,
    input  logic                                 flush,
    output logic [REG_FILE_SIZE-1:0]             sb_o,
    output logic [REG_FILE_SIZE*REG_VAL_W-1:0]   reg_file_o,
    output logic [$clog2(REG_FILE_SIZE):0]       inflight_o,
    output logic                                 idle_o,
    output logic [1:0]                           err_o
);

    localparam int unsigned IDX_W = $clog2(REG_FILE_SIZE);
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam int unsigned RSP_NUM = 4;
    localparam logic [REG_ID_W-1:0] ID_LIMIT = REG_ID_W'(REG_FILE_SIZE);
    localparam logic [REG_VAL_W-1:0] RSP_RESET = REG_VAL_W'({RSP_INIT, 4'b0000});

    logic [REG_FILE_SIZE-1:0] r_sb;
    logic [REG_VAL_W-1:0]     r_rf [REG_FILE_SIZE];
    logic [CNT_W-1:0]         r_inflight;
    logic                     r_idle;
    logic [1:0]               r_err;

    logic                     w_wb_hit;
    logic                     w_rsv_hit;
    logic [IDX_W-1:0]         w_wb_n;
    logic [IDX_W-1:0]         w_rsv_n;
    logic                     w_wb_acc;
    logic [REG_FILE_SIZE-1:0] w_sb_next;
    logic [CNT_W-1:0]         w_cnt;
    logic [1:0]               w_err_next;

    assign w_wb_hit  = wb_valid && (wb_id < ID_LIMIT);
    assign w_rsv_hit = rsv_valid && (rsv_id < ID_LIMIT);
    assign w_wb_n    = wb_id[IDX_W-1:0];
    assign w_rsv_n   = rsv_id[IDX_W-1:0];
    assign w_wb_acc  = w_wb_hit && r_sb[w_wb_n];

    // Scoreboard next state and error events; priority flush > reserve > writeback-clear.
    always_comb begin
        w_sb_next  = r_sb;
        w_err_next = r_err;
        if (w_wb_hit && !r_sb[w_wb_n]) begin
            w_err_next[1] = 1'b1;
        end
        if (w_wb_acc) begin
            w_sb_next[w_wb_n] = 1'b0;
        end
        if (w_rsv_hit && !flush) begin
            // A same-cycle accepted writeback frees the slot for the new writer.
            if (!r_sb[w_rsv_n] || (w_wb_acc && (w_wb_n == w_rsv_n))) begin
                w_sb_next[w_rsv_n] = 1'b1;
            end else begin
                w_err_next[0] = 1'b1;
            end
        end
        if (flush) begin
            w_sb_next = '0;
        end
    end

    // Population count of the next-state scoreboard.
    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < REG_FILE_SIZE; i++) begin
            w_cnt = w_cnt + CNT_W'(w_sb_next[i]);
        end
    end

    // Scoreboard, counters and sticky errors.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sb       <= '0;
            r_inflight <= '0;
            r_idle     <= 1'b1;
            r_err      <= '0;
        end else begin
            r_sb       <= w_sb_next;
            r_inflight <= w_cnt;
            r_idle     <= (w_sb_next == '0);
            r_err      <= w_err_next;
        end
    end

    // Register values; only accepted writebacks update, flush leaves values alone.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < REG_FILE_SIZE; i++) begin
                r_rf[i] <= (i == RSP_NUM) ? RSP_RESET : '0;
            end
        end else if (w_wb_acc) begin
            r_rf[w_wb_n] <= wb_val;
        end
    end

    for (genvar g = 0; g < REG_FILE_SIZE; g++) begin : g_rf_out
        assign reg_file_o[g*REG_VAL_W +: REG_VAL_W] = r_rf[g];
    end

    assign sb_o       = r_sb;
    assign inflight_o = r_inflight;
    assign idle_o     = r_idle;
    assign err_o      = r_err;

endmodule

// File: tb/tb_musk_reg_writeback.sv
// Scoreboard bench for musk_reg_writeback: a reference model predicts the state after
// every cycle, pushes it to a queue, and the queue is popped and compared after the edge.
module tb_musk_reg_writeback;

    localparam int unsigned N = 16;
    localparam int unsigned VW = 68;
    localparam logic [63:0] RSP_INIT = 64'h7fff_0000;

    localparam logic [4:0] RAX = 5'd0;
    localparam logic [4:0] RCX = 5'd1;
    localparam logic [4:0] RDX = 5'd2;
    localparam logic [4:0] RBX = 5'd3;
    localparam logic [4:0] RNIL = 5'd18;
    localparam logic [4:0] RIMM = 5'd17;
    localparam logic [4:0] RSYSCALL = 5'd21;

    logic              clk;
    logic              reset_n;
    logic              rsv_valid;
    logic [4:0]        rsv_id;
    logic              wb_valid;
    logic [4:0]        wb_id;
    logic [VW-1:0]     wb_val;
    logic              flush;
    logic [N-1:0]      sb_o;
    logic [N*VW-1:0]   reg_file_o;
    logic [4:0]        inflight_o;
    logic              idle_o;
    logic [1:0]        err_o;

    musk_reg_writeback #(
        .REG_FILE_SIZE(N),
        .REG_ID_W(5),
        .REG_VAL_W(VW),
        .RSP_INIT(RSP_INIT)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .rsv_valid(rsv_valid),
        .rsv_id(rsv_id),
        .wb_valid(wb_valid),
        .wb_id(wb_id),
        .wb_val(wb_val),
        .flush(flush),
        .sb_o(sb_o),
        .reg_file_o(reg_file_o),
        .inflight_o(inflight_o),
        .idle_o(idle_o),
        .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0]    sb;
        logic [4:0]      inflight;
        logic            idle;
        logic [1:0]      err;
        logic [N*VW-1:0] rf;
    } exp_t;

    exp_t         exp_q[$];
    logic [N-1:0] m_sb;
    logic [1:0]   m_err;
    logic [VW-1:0] m_rf [N];
    int           n_checks = 0;
    int           n_fail = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_sb  = '0;
        m_err = '0;
        for (int i = 0; i < N; i++) m_rf[i] = '0;
        m_rf[4] = {RSP_INIT, 4'b0000};
    endtask

    task automatic model_step(input logic rv, input logic [4:0] rid, input logic wv,
                              input logic [4:0] wid, input logic [VW-1:0] val, input logic fl);
        logic [N-1:0] nsb;
        logic         wb_in;
        logic         rv_in;
        logic         wb_ok;
        nsb   = m_sb;
        wb_in = wv && (wid < 5'd16);
        rv_in = rv && (rid < 5'd16);
        wb_ok = wb_in && m_sb[wid[3:0]];
        if (wb_in && !wb_ok) m_err[1] = 1'b1;
        if (wb_ok) begin
            m_rf[wid[3:0]] = val;
            nsb[wid[3:0]]  = 1'b0;
        end
        if (rv_in && !fl) begin
            if (m_sb[rid[3:0]] && !(wb_ok && (wid == rid))) m_err[0] = 1'b1;
            else nsb[rid[3:0]] = 1'b1;
        end
        if (fl) nsb = '0;
        m_sb = nsb;
    endtask

    task automatic push_exp();
        exp_t e;
        e.sb       = m_sb;
        e.inflight = 5'($countones(m_sb));
        e.idle     = (m_sb == '0);
        e.err      = m_err;
        for (int i = 0; i < N; i++) e.rf[i*VW +: VW] = m_rf[i];
        exp_q.push_back(e);
    endtask

    task automatic pop_compare();
        exp_t e;
        if (exp_q.size() == 0) begin
            check("queue_empty", 128'd1, 128'd0);
            return;
        end
        e = exp_q.pop_front();
        check("sb", 128'(sb_o), 128'(e.sb));
        check("inflight", 128'(inflight_o), 128'(e.inflight));
        check("idle", 128'(idle_o), 128'(e.idle));
        check("err", 128'(err_o), 128'(e.err));
        for (int i = 0; i < N; i++) begin
            check($sformatf("rf[%0d]", i), 128'(reg_file_o[i*VW +: VW]), 128'(e.rf[i*VW +: VW]));
        end
    endtask

    task automatic cycle(input logic rv, input logic [4:0] rid, input logic wv,
                         input logic [4:0] wid, input logic [VW-1:0] val, input logic fl);
        @(negedge clk);
        rsv_valid = rv;
        rsv_id    = rid;
        wb_valid  = wv;
        wb_id     = wid;
        wb_val    = val;
        flush     = fl;
        model_step(rv, rid, wv, wid, val, fl);
        push_exp();
        @(posedge clk);
        #1;
        pop_compare();
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 5'd0, 1'b0, 5'd0, '0, 1'b0);
    endtask

    initial begin
        reset_n   = 1'b0;
        rsv_valid = 1'b0;
        rsv_id    = '0;
        wb_valid  = 1'b0;
        wb_id     = '0;
        wb_val    = '0;
        flush     = 1'b0;
        #12;
        model_reset();
        push_exp();
        pop_compare();
        check("rsp_reset_val", 128'(reg_file_o[4*VW+4 +: 64]), 128'(64'h7fff_0000));
        @(negedge clk);
        reset_n = 1'b1;

        // Reserve rax, wait, writeback with zf set.
        cycle(1'b1, RAX, 1'b0, 5'd0, '0, 1'b0);
        check("rax_inflight", 128'(inflight_o), 128'd1);
        idle_cycle();
        idle_cycle();
        cycle(1'b0, 5'd0, 1'b1, RAX, {64'h1234, 4'b0100}, 1'b0);
        check("rax_val", 128'(reg_file_o[0 +: VW]), 128'({64'h1234, 4'b0100}));
        check("idle_after_wb", 128'(idle_o), 128'd1);

        // Same-cycle writeback and re-reserve of a busy register.
        cycle(1'b1, RAX, 1'b0, 5'd0, '0, 1'b0);
        cycle(1'b1, RAX, 1'b1, RAX, {64'd5, 4'b0000}, 1'b0);
        check("rax_rebusy", 128'(sb_o[0]), 128'd1);
        check("no_err", 128'(err_o), 128'd0);
        cycle(1'b0, 5'd0, 1'b1, RAX, {64'd6, 4'b0000}, 1'b0);

        // Fill the scoreboard, then flush with a writeback.
        for (int i = 0; i < 16; i++) cycle(1'b1, 5'(i), 1'b0, 5'd0, '0, 1'b0);
        check("full_inflight", 128'(inflight_o), 128'd16);
        cycle(1'b0, 5'd0, 1'b1, RBX, {64'd9, 4'b0000}, 1'b1);
        check("rbx_after_flush", 128'(reg_file_o[3*VW +: VW]), 128'({64'd9, 4'b0000}));
        check("flush_inflight", 128'(inflight_o), 128'd0);

        // Protocol errors.
        cycle(1'b0, 5'd0, 1'b1, RCX, {64'hdead, 4'b1111}, 1'b0);
        check("err_wb", 128'(err_o), 128'b10);
        cycle(1'b1, RDX, 1'b0, 5'd0, '0, 1'b0);
        cycle(1'b1, RDX, 1'b0, 5'd0, '0, 1'b0);
        check("err_both", 128'(err_o), 128'b11);

        // Non-file ids are ignored on both ports.
        cycle(1'b1, RNIL, 1'b1, RIMM, {64'hbad, 4'b0001}, 1'b0);
        cycle(1'b1, RSYSCALL, 1'b1, RSYSCALL, {64'hbad, 4'b0001}, 1'b0);
        cycle(1'b1, RIMM, 1'b1, RNIL, {64'hbad, 4'b0001}, 1'b0);

        // Random traffic.
        for (int k = 0; k < 60; k++) begin
            cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 21)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 21)),
                  {$urandom, $urandom, 4'($urandom)}, ($urandom_range(0, 7) == 0));
        end

        // Asynchronous reset in the middle of a reservation.
        cycle(1'b1, RAX, 1'b0, 5'd0, '0, 1'b0);
        @(negedge clk);
        rsv_valid = 1'b0;
        wb_valid  = 1'b0;
        flush     = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        model_reset();
        push_exp();
        pop_compare();
        @(negedge clk);
        reset_n = 1'b1;
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/musk_reg_writeback.md
Name: musk_reg_writeback

Overview:
- Owns the architectural register file and its scoreboard; it is the write side of the scoreboard and register-read helpers used at issue.
- Issue reserves a destination by setting its scoreboard bit.
- Execute/memory writeback writes the result value and clears the bit.
- Pipeline squash clears all reservations.
- Outputs `sb_o` and `reg_file_o` feed the issue stage's scoreboard checks and operand reads directly.

Parameters:
- REG_FILE_SIZE, 16, number of architectural GPRs; `sb_o` bit i corresponds to `reg_num` i.
- REG_VAL_W, $bits(reg_val_t), width of one packed register value (64-bit val plus flags cf/zf/sf/of).
- RSP_INIT, 64'h0, reset value of `reg_file_o[reg_num(rsp)].val`.

Ports:
- clk  in  1  core clock.
- reset_n  in  1  asynchronous, active-low reset.
- rsv_valid  in  1  issue reserves `rsv_id` this cycle.
- rsv_id  in  $bits(reg_id_t)  destination register id being reserved.
- wb_valid  in  1  writeback of `wb_val` to `wb_id` this cycle.
- wb_id  in  $bits(reg_id_t)  writeback destination id.
- wb_val  in  REG_VAL_W  result value including flags.
- flush  in  1  squash; drop all outstanding reservations.
- sb_o  out  REG_FILE_SIZE  scoreboard; bit set means the register has a pending writer.
- reg_file_o  out  REG_FILE_SIZE*REG_VAL_W  registered register file contents.
- inflight_o  out  $clog2(REG_FILE_SIZE)+1  population count of `sb_o`.
- idle_o  out  1  high when `sb_o`==0; gates rsyscall issue.
- err_o  out  2  sticky protocol errors: [0] reserve of a busy reg, [1] writeback to an unreserved reg.

Behaviour:
- Reset (async, reset_n low):
  - all `reg_file_o` entries = 0, except rsp.val = RSP_INIT;
  - `sb_o` = 0, `inflight_o` = 0, `idle_o` = 1, `err_o` = 0.
- Only ids where `reg_in_file(id)` is true act on state. rnil, rip, rimm, rv0, rv8 and rsyscall are ignored on both ports: no state change, no error.
- All state updates on posedge clk. Outputs are registered, so an update is visible one cycle after the request.
- Writeback (wb_valid, file id n):
  - If `sb_o[n]`=1: `reg_file_o[n]` <= wb_val (whole packed value, flags included) and `sb_o[n]` <= 0.
  - If `sb_o[n]`=0: the write is dropped and `err_o[1]` <= 1.
- Reserve (rsv_valid, file id n, no flush):
  - If `sb_o[n]`=0, or a writeback to n is accepted in the same cycle: `sb_o[n]` <= 1.
  - If `sb_o[n]`=1 and no same-cycle writeback to n: `err_o[0]` <= 1 and the bit stays 1.
- Same-cycle writeback and reserve to the same reg: the value is written and the bit ends at 1, because the new writer follows the old one.
- Flush:
  - Next-state `sb_o` = 0, and any same-cycle reserve is discarded.
  - A same-cycle writeback to a reserved reg still writes its value; the error rule is evaluated against pre-flush `sb_o`.
  - Register values are otherwise untouched.
- Next-state priority for `sb_o`: flush > reserve > writeback-clear.
- `inflight_o` is recomputed combinationally from the next-state `sb_o` and registered with it, so it always equals popcount(`sb_o`). Range 0..REG_FILE_SIZE; 16 is reachable and must not wrap.
- `idle_o` = (`sb_o`==0), registered with `sb_o`.
- `err_o` bits are sticky until reset. An error event never blocks the other port's action in the same cycle.
- Reset asserted mid-operation immediately forces the reset values; pending reservations are lost.
- No handshake backpressure: the block always accepts. Issue is responsible for checking `sb_o` before asserting `rsv_valid`.

Test Plan:
- Reset with RSP_INIT=64'h7fff_0000 → rsp.val=64'h7fff_0000, rax=0, `sb_o`=0, `idle_o`=1, `inflight_o`=0, `err_o`=0.
- Reserve rax at cycle 0; writeback rax val=64'h1234, zf=1 at cycle 3 → cycles 1-3 `sb_o[rax]`=1, `idle_o`=0, `inflight_o`=1; cycle 4 rax.val=64'h1234, zf=1, `sb_o`=0, `idle_o`=1.
- rax reserved; same cycle writeback rax=5 and reserve rax → next cycle rax.val=5, `sb_o[rax]`=1, `err_o`=0.
- Reserve all 16 regs over 16 cycles → `inflight_o`=16; then flush plus writeback rbx=9 in the same cycle → `sb_o`=0, `inflight_o`=0, rbx.val=9, other values unchanged.
- Writeback rcx with no reservation → rcx unchanged, `err_o`=2'b10. Then reserve rdx twice without a writeback → `err_o`=2'b11, `sb_o[rdx]`=1.
- Reserve/writeback using rnil, rimm and rsyscall → no change to `sb_o`, `reg_file_o` or `err_o`. Reset mid-reservation → all reset values restored asynchronously.
